class_argmax_unit: RTL and testbench
====================================

// Module: class_argmax_unit
// PURPOSE
//  Streaming arg-max stage between the MobileNetV3 classifier head and disease_names_rom.
//  Consumes one signed class score per beat (class 0 first) and tracks the running maximum.
//  Emits the winning class index, its score and the top-1/top-2 margin; class_index drives
//  the ROM's class_index input. Flags malformed frames (wrong beat count).
// PARAMETERS
//  NUM_CLASSES  15  number of score beats per frame (classes 0..NUM_CLASSES-1)
//  SCORE_WIDTH  16  signed score width (Q8.8 logits)
//  IDX_W        $clog2(NUM_CLASSES)  index width (localparam, not overridable)
// PORTS
//  clk          in   1             single clock; all logic on rising edge
//  rst_n        in   1             synchronous active-low reset
//  score_valid  in   1             input beat valid
//  score_ready  out  1             input beat accepted when valid&&ready
//  score_data   in   SCORE_WIDTH   signed class score for current class
//  score_last   in   1             marks final beat of frame
//  result_valid out  1             result held stable while high
//  result_ready in   1             downstream accepts result when valid&&ready
//  class_index  out  IDX_W         winning class index (to disease_names_rom)
//  class_score  out  SCORE_WIDTH   signed score of winner
//  margin       out  SCORE_WIDTH+1 unsigned top1-top2 difference, 0 if fewer than 2 valid beats
//  length_err   out  1             frame beat count != NUM_CLASSES; valid with result_valid
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, beat count=0, all outputs 0 incl. score_ready;
//   score_ready rises the cycle after rst_n is sampled high. Reset mid-frame discards the frame.
//  States: IDLE -> ACCUM on first accepted beat; ACCUM -> RESULT on accepted beat with
//   score_last=1 (a first beat with last=1 goes IDLE -> RESULT directly);
//   RESULT -> IDLE on result_valid&&result_ready.
//  score_ready = 1 in IDLE/ACCUM, 0 in RESULT (no input accepted while a result is pending).
//  Beat count cnt: 0 on frame start, +1 per accepted beat; the beat index is cnt before increment.
//  First beat: top1=score, idx=0, top2=most-negative (invalid flag clear).
//  Later beat with index < NUM_CLASSES: signed compare; score > top1 -> top2<=top1,
//   top1<=score, idx<=beat index; else score > top2 -> top2<=score. Ties keep lower index.
//  Beats with index >= NUM_CLASSES: accepted, excluded from compare, set overflow flag;
//   cnt saturates at NUM_CLASSES.
//  margin = top1 - top2 in SCORE_WIDTH+1 bits (no overflow possible); 0 when only one
//   in-range beat was received.
//  length_err = 1 if last beat arrived at beat index != NUM_CLASSES-1 (short or long frame).
//  Latency: result_valid asserts the cycle after the last beat is accepted. Outputs are
//   registered and stable until handshake; result_valid falls the cycle after the handshake.
//   score_ready returns high that same cycle (one bubble cycle between frames).
//  result_ready held high continuously: one frame per NUM_CLASSES+1 cycles.
//  score_valid may deassert mid-frame; the state is held and no timeout applies.
//  score_data/score_last are ignored when score_valid=0 or score_ready=0.
// TESTING
//  T1 15 beats, scores all -1.0 except class 9 = +3.5 (0x0380), last on beat 14
//     -> class_index=9, class_score=0x0380, margin=0x0480, length_err=0, valid 1 cycle after last.
//  T2 tie: classes 4 and 11 both 0x0200, others 0x0000 -> class_index=4, margin=0.
//  T3 short frame: last on beat 7, max at class 2 -> result with class_index=2, length_err=1;
//     long frame of 17 beats with max 0x7FFF at beat 16 -> winner is in-range max, length_err=1.
//  T4 backpressure: result_ready=0 for 10 cycles -> score_ready=0 and outputs stable throughout;
//     next frame is accepted only after the handshake.
//  T5 extremes: class 0=0x7FFF, all others 0x8000 -> class_index=0, margin=0x0FFFF.
//  T6 rst_n=0 after beat 6, then a full frame -> no stale result; new result is correct;
//     single-beat frame (last on beat 0) -> class_index=0, margin=0, length_err=1.

Source files
------------

// File: rtl/class_argmax_unit.sv
// Streaming arg-max over one frame of signed class scores, one beat per class.
// Holds the winning index, its score and the top-1/top-2 margin until the result is taken.
module class_argmax_unit #(
  parameter int NUM_CLASSES = 15,
  parameter int SCORE_WIDTH = 16,
  localparam int IDX_W = $clog2(NUM_CLASSES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          score_valid,
  output logic                          score_ready,
  input  logic signed [SCORE_WIDTH-1:0] score_data,
  input  logic                          score_last,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [IDX_W-1:0]              class_index,
  output logic [SCORE_WIDTH-1:0]        class_score,
  output logic [SCORE_WIDTH:0]          margin,
  output logic                          length_err
);

  // The counter must reach NUM_CLASSES itself, where it saturates on long frames.
  localparam int CNT_W = $clog2(NUM_CLASSES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  function automatic logic [SCORE_WIDTH:0] calc_margin(
    input logic signed [SCORE_WIDTH-1:0] hi,
    input logic signed [SCORE_WIDTH-1:0] lo,
    input logic                          vld
  );
    logic [SCORE_WIDTH:0] diff;
    diff = {hi[SCORE_WIDTH-1], hi} - {lo[SCORE_WIDTH-1], lo};
    if (vld) begin
      return diff;
    end else begin
      return {(SCORE_WIDTH+1){1'b0}};
    end
  endfunction

  state_t                        state_r, state_s;
  logic [CNT_W-1:0]              cnt_r, cnt_s;
  logic signed [SCORE_WIDTH-1:0] top1_r, top1_s;
  logic signed [SCORE_WIDTH-1:0] top2_r, top2_s;
  logic [IDX_W-1:0]              idx_r, idx_s;
  logic                          top2_vld_r, top2_vld_s;
  logic                          ovf_r, ovf_s;

  logic                          score_ready_r;
  logic                          result_valid_r;
  logic [IDX_W-1:0]              class_index_r;
  logic [SCORE_WIDTH-1:0]        class_score_r;
  logic [SCORE_WIDTH:0]          margin_r;
  logic                          length_err_r;

  logic                          accept_s;
  logic                          first_s;
  logic [CNT_W-1:0]              beat_idx_s;
  logic                          in_range_s;
  logic                          last_acc_s;
  logic                          handshake_s;

  // Handshake qualifiers and the index of the beat being accepted.
  always_comb begin
    accept_s    = score_valid && score_ready_r;
    first_s     = (state_r == ST_IDLE);
    last_acc_s  = accept_s && score_last;
    handshake_s = result_valid_r && result_ready;
    if (first_s) begin
      beat_idx_s = {CNT_W{1'b0}};
    end else begin
      beat_idx_s = cnt_r;
    end
    in_range_s = (beat_idx_s < CNT_W'(NUM_CLASSES));
  end

  // Running top-1 / top-2 tracker; strict compares keep the lower index on ties.
  always_comb begin
    cnt_s      = cnt_r;
    top1_s     = top1_r;
    top2_s     = top2_r;
    idx_s      = idx_r;
    top2_vld_s = top2_vld_r;
    ovf_s      = ovf_r;
    if (accept_s) begin
      if (in_range_s) begin
        cnt_s = beat_idx_s + CNT_W'(1);
      end else begin
        cnt_s = beat_idx_s;
      end
      if (first_s) begin
        top1_s     = score_data;
        top2_s     = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
        idx_s      = {IDX_W{1'b0}};
        top2_vld_s = 1'b0;
        ovf_s      = 1'b0;
      end else if (in_range_s) begin
        // Any second in-range beat makes the margin meaningful, even at the most-negative score.
        top2_vld_s = 1'b1;
        if (score_data > top1_r) begin
          top2_s = top1_r;
          top1_s = score_data;
          idx_s  = IDX_W'(beat_idx_s);
        end else if (score_data > top2_r) begin
          top2_s = score_data;
        end else begin
          top2_s = top2_r;
        end
      end else begin
        ovf_s = 1'b1;
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = score_last ? ST_RESULT : ST_ACCUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_acc_s) begin
          state_s = ST_RESULT;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_RESULT: begin
        if (handshake_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESULT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Tracker registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      top1_r     <= {SCORE_WIDTH{1'b0}};
      top2_r     <= {SCORE_WIDTH{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      top2_vld_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      top1_r     <= top1_s;
      top2_r     <= top2_s;
      idx_r      <= idx_s;
      top2_vld_r <= top2_vld_s;
      ovf_r      <= ovf_s;
    end
  end

  // Output registers: the result is captured from the tracker's next values on the last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_ready_r  <= 1'b0;
      result_valid_r <= 1'b0;
      class_index_r  <= {IDX_W{1'b0}};
      class_score_r  <= {SCORE_WIDTH{1'b0}};
      margin_r       <= {(SCORE_WIDTH+1){1'b0}};
      length_err_r   <= 1'b0;
    end else begin
      score_ready_r  <= (state_s != ST_RESULT);
      result_valid_r <= (state_s == ST_RESULT);
      if (last_acc_s) begin
        class_index_r <= idx_s;
        class_score_r <= top1_s;
        margin_r      <= calc_margin(top1_s, top2_s, top2_vld_s);
        length_err_r  <= (beat_idx_s != CNT_W'(NUM_CLASSES - 1)) || ovf_s;
      end else begin
        class_index_r <= class_index_r;
        class_score_r <= class_score_r;
        margin_r      <= margin_r;
        length_err_r  <= length_err_r;
      end
    end
  end

  assign score_ready  = score_ready_r;
  assign result_valid = result_valid_r;
  assign class_index  = class_index_r;
  assign class_score  = class_score_r;
  assign margin       = margin_r;
  assign length_err   = length_err_r;

endmodule

// File: tb/tb_class_argmax_unit.sv
// Bench for class_argmax_unit: directed frames, a frame-level reference model and
// per-cycle output comparison, plus literal expectations for each scenario.
module tb_class_argmax_unit;
  localparam int N = 15;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         score_valid;
  logic         score_ready;
  logic [W-1:0] score_data;
  logic         score_last;
  logic         result_valid;
  logic         result_ready;
  logic [3:0]   class_index;
  logic [W-1:0] class_score;
  logic [W:0]   margin;
  logic         length_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  class_argmax_unit #(.NUM_CLASSES(N), .SCORE_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .score_valid(score_valid), .score_ready(score_ready),
    .score_data(score_data), .score_last(score_last),
    .result_valid(result_valid), .result_ready(result_ready),
    .class_index(class_index), .class_score(class_score),
    .margin(margin), .length_err(length_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted beats of the current frame, expected result and handshake state.
  logic signed [W-1:0] fr[$];
  bit           m_ready   = 1'b0;
  bit           m_pend    = 1'b0;
  bit           m_started = 1'b0;
  int           e_idx;
  logic [W-1:0] e_score;
  logic [W:0]   e_margin;
  bit           e_err;

  function automatic void compute();
    int n, m, best;
    bit have;
    logic signed [W-1:0] sec;
    n = fr.size();
    m = (n < N) ? n : N;
    best = 0;
    for (int i = 1; i < m; i++) if (fr[i] > fr[best]) best = i;
    e_idx   = best;
    e_score = fr[best];
    e_err   = (n != N);
    if (m < 2) begin
      e_margin = '0;
    end else begin
      have = 1'b0;
      sec  = '0;
      for (int j = 0; j < m; j++)
        if (j != best && (!have || fr[j] > sec)) begin
          sec  = fr[j];
          have = 1'b1;
        end
      e_margin = 17'(int'(fr[best]) - int'(sec));
    end
  endfunction

  always @(posedge clk) begin
    m_started = 1'b1;
    if (!rst_n) begin
      m_ready = 1'b0;
      m_pend  = 1'b0;
      fr.delete();
    end else if (m_pend) begin
      if (result_ready) begin
        m_pend  = 1'b0;
        m_ready = 1'b1;
      end
    end else begin
      if (m_ready && score_valid) begin
        fr.push_back(score_data);
        if (score_last) begin
          compute();
          fr.delete();
          m_pend = 1'b1;
        end
      end
      m_ready = !m_pend;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("score_ready", 32'(score_ready), 32'(m_ready));
      chk("result_valid", 32'(result_valid), 32'(m_pend));
      if (m_pend) begin
        chk("class_index", 32'(class_index), 32'(e_idx));
        chk("class_score", 32'(class_score), 32'(e_score));
        chk("margin", 32'(margin), 32'(e_margin));
        chk("length_err", 32'(length_err), 32'(e_err));
      end
    end
  end

  logic [W-1:0] vec [0:31];

  task automatic wait_ready();
    int g = 0;
    while (score_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l);
    wait_ready();
    score_valid = 1'b1;
    score_data  = d;
    score_last  = l;
    @(negedge clk);
    score_valid = 1'b0;
    score_data  = 16'h7FFF;
    score_last  = 1'b1;
  endtask

  task automatic send_vec(input int len, input int gap_at);
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) repeat (2) @(negedge clk);
      beat(vec[i], (i == len - 1));
    end
  endtask

  task automatic lit(input string nm, input int idx, input logic [W-1:0] sc,
                     input logic [W:0] mg, input logic le);
    chk({nm, "_valid"}, 32'(result_valid), 32'd1);
    chk({nm, "_idx"}, 32'(class_index), 32'(idx));
    chk({nm, "_score"}, 32'(class_score), 32'(sc));
    chk({nm, "_margin"}, 32'(margin), 32'(mg));
    chk({nm, "_lerr"}, 32'(length_err), 32'(le));
  endtask

  initial begin
    rst_n        = 1'b0;
    score_valid  = 1'b0;
    score_data   = 16'h0000;
    score_last   = 1'b0;
    result_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(score_ready), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_margin", 32'(margin), 32'd0);
    rst_n = 1'b1;

    // T1: single clear winner at class 9
    for (int i = 0; i < N; i++) vec[i] = 16'hFF00;
    vec[9] = 16'h0380;
    send_vec(N, -1);
    lit("t1", 9, 16'h0380, 17'h00480, 1'b0);

    // T2: tie between classes 4 and 11, with a mid-frame valid gap
    for (int i = 0; i < N; i++) vec[i] = 16'h0000;
    vec[4]  = 16'h0200;
    vec[11] = 16'h0200;
    send_vec(N, 6);
    lit("t2", 4, 16'h0200, 17'h00000, 1'b0);

    // T3: short frame then long frame
    vec[0] = 16'd10; vec[1] = 16'd20; vec[2] = 16'd300; vec[3] = 16'd5;
    vec[4] = 16'hFFF9; vec[5] = 16'd0; vec[6] = 16'd1; vec[7] = 16'd2;
    send_vec(8, -1);
    lit("t3s", 2, 16'h012C, 17'h00118, 1'b1);
    for (int i = 0; i < N; i++) vec[i] = 16'(i * 16);
    vec[15] = 16'h0000;
    vec[16] = 16'h7FFF;
    send_vec(17, -1);
    lit("t3l", 14, 16'h00E0, 17'h00010, 1'b1);

    // T4: result backpressure with input beats offered throughout
    wait_ready();
    result_ready = 1'b0;
    for (int i = 0; i < N; i++) vec[i] = 16'h0010;
    vec[3] = 16'h0100;
    send_vec(N, -1);
    score_valid = 1'b1;
    score_data  = 16'h7FFF;
    score_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_ready", 32'(score_ready), 32'd0);
      chk("t4_hold_idx", 32'(class_index), 32'd3);
      @(negedge clk);
    end
    lit("t4", 3, 16'h0100, 17'h000F0, 1'b0);
    score_valid  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    chk("t4_released", 32'(result_valid), 32'd0);

    // T5: extreme scores
    for (int i = 0; i < N; i++) vec[i] = 16'h8000;
    vec[0] = 16'h7FFF;
    send_vec(N, -1);
    lit("t5", 0, 16'h7FFF, 17'h0FFFF, 1'b0);

    // T6: reset mid-frame, then a full frame and a single-beat frame
    wait_ready();
    for (int i = 0; i < 7; i++) beat(16'h0400, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(result_valid), 32'd0);
    chk("t6_rst_ready", 32'(score_ready), 32'd0);
    chk("t6_rst_idx", 32'(class_index), 32'd0);
    chk("t6_rst_score", 32'(class_score), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) vec[i] = 16'(-i);
    vec[14] = 16'h0050;
    send_vec(N, -1);
    lit("t6f", 14, 16'h0050, 17'h00050, 1'b0);
    beat(16'h1234, 1'b1);
    lit("t6s", 0, 16'h1234, 17'h00000, 1'b1);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
